bit_serializer: RTL and testbench

//  Converts parallel words, delivered over a valid/ready handshake, into a

---
 rtl/bit_serializer.sv | 140 ++++++++++++++
 tb/tb_bit_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: valid/ready word input, one bit per clock out,
// with a single holding register so back-to-back words stream without gaps.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no word in flight, ser_data parked at IDLE_BIT
// S_SHIFT| a word is on ser_data; bit_cnt_q = bits still to follow
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ser_data_q, ser_data_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;

    logic             accept;
    logic             do_load;
    logic [WIDTH-1:0] load_word;

    // The bit that leaves next sits at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_on(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready = ~hold_valid_q & ~rst;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        sreg_d        = sreg_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        bit_cnt_d     = bit_cnt_q;
        ser_data_d    = ser_data_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = 1'b0;
        do_load       = 1'b0;
        load_word     = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    do_load   = 1'b1;
                    load_word = in_data;
                end else begin
                    ser_data_d  = IDLE_BIT;
                    ser_valid_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    ser_data_d = out_bit(sreg_q);
                    sreg_d     = shift_on(sreg_q);
                    bit_cnt_d  = bit_cnt_q - CW'(1);
                    if (accept) begin
                        hold_d       = in_data;
                        hold_valid_d = 1'b1;
                    end
                end else if (hold_valid_q) begin
                    do_load      = 1'b1;
                    load_word    = hold_q;
                    hold_valid_d = 1'b0;
                end else if (accept) begin
                    do_load   = 1'b1;
                    load_word = in_data;
                end else begin
                    state_d     = S_IDLE;
                    ser_valid_d = 1'b0;
                    ser_data_d  = IDLE_BIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh word puts its first bit on the wire at the same edge it loads.
        if (do_load) begin
            sreg_d        = shift_on(load_word);
            ser_data_d    = out_bit(load_word);
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            bit_cnt_d     = CW'(WIDTH - 1);
            state_d       = S_SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sreg_q        <= '0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            bit_cnt_q     <= '0;
            ser_data_q    <= IDLE_BIT;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            bit_cnt_q     <= bit_cnt_d;
            ser_data_q    <= ser_data_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign ser_data    = ser_data_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = ser_valid_q | hold_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are compared against a bit-queue model every cycle.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready_m, ser_data_m, ser_valid_m, frame_start_m, busy_m;
    logic         in_ready_l, ser_data_l, ser_valid_l, frame_start_l, busy_l;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .ser_data(ser_data_m), .ser_valid(ser_valid_m),
        .frame_start(frame_start_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .ser_data(ser_data_l), .ser_valid(ser_valid_l),
        .frame_start(frame_start_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: every accepted word becomes W queued {first,bit} entries; each
    // clock the head entry moves onto the wire. The hold register is full
    // exactly when a whole word waits behind the bits of the current one.
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    logic       em_data, em_valid, em_fs;
    logic       el_data, el_fs;
    logic       last_acc;

    logic [7:0]  cap_m, cap_l;
    logic [15:0] cap16;
    int          vcnt, fscnt, rdylo, detcnt;
    logic [2:0]  hist_o, hist_e;

    task automatic model_edge();
        logic [1:0] e;
        last_acc = in_valid && !rst && (qm.size() < W);
        if (rst) begin
            qm.delete();
            ql.delete();
            em_data = 1'b0; em_valid = 1'b0; em_fs = 1'b0;
            el_data = 1'b1; el_fs = 1'b0;
        end else begin
            if (last_acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back({i == 0, in_data[W-1-i]});
                    ql.push_back({i == 0, in_data[i]});
                end
            end
            if (qm.size() > 0) begin
                e = qm.pop_front();
                em_data = e[0]; em_fs = e[1]; em_valid = 1'b1;
                e = ql.pop_front();
                el_data = e[0]; el_fs = e[1];
            end else begin
                em_data = 1'b0; em_valid = 1'b0; em_fs = 1'b0;
                el_data = 1'b1; el_fs = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_busy;
        exp_busy = em_valid | (qm.size() >= W);
        chk("ser_data_m", ser_data_m, em_data);
        chk("ser_valid_m", ser_valid_m, em_valid);
        chk("frame_start_m", frame_start_m, em_fs);
        chk("busy_m", busy_m, exp_busy);
        chk("ser_data_l", ser_data_l, el_data);
        chk("ser_valid_l", ser_valid_l, em_valid);
        chk("frame_start_l", frame_start_l, el_fs);
        chk("busy_l", busy_l, exp_busy);
        if (ser_valid_m) begin
            cap_m = {cap_m[6:0], ser_data_m};
            cap16 = {cap16[14:0], ser_data_m};
            cap_l = {ser_data_l, cap_l[7:1]};
            vcnt++;
        end
        if (frame_start_m) fscnt++;
        hist_o = {hist_o[1:0], ser_data_m};
        hist_e = {hist_e[1:0], em_data};
        if (hist_o == 3'b101) detcnt++;
        chk("det_101", hist_o == 3'b101, hist_e == 3'b101);
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] d);
        logic exp_rdy;
        @(negedge clk);
        check_outputs();
        rst = r; in_valid = v; in_data = d;
        #1;
        exp_rdy = !r && (qm.size() < W);
        chk("in_ready_m", in_ready_m, exp_rdy);
        chk("in_ready_l", in_ready_l, exp_rdy);
        if (!in_ready_m && !r) rdylo++;
        @(posedge clk);
        model_edge();
    endtask

    task automatic clear_stats();
        vcnt = 0; fscnt = 0; rdylo = 0; detcnt = 0;
        cap_m = '0; cap_l = '0; cap16 = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    logic         cur_v;
    logic [W-1:0] cur_d;
    logic         r_rand;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        em_data = 1'b0; em_valid = 1'b0; em_fs = 1'b0;
        el_data = 1'b1; el_fs = 1'b0; last_acc = 1'b0;
        hist_o = '0; hist_e = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", ser_valid_m, 1'b0);
        chk("rst_fs", frame_start_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_ready", in_ready_m, 1'b0);
        chk("rst_idle_l", ser_data_l, 1'b1);
        step(1'b1, 1'b0, '0);
        idle(1);

        // single word 0xA5
        clear_stats();
        step(1'b0, 1'b1, 8'hA5);
        #2;
        chk("a5_first_fs", frame_start_m, 1'b1);
        idle(9);
        chk("a5_bits_m", cap_m, 8'hA5);
        chk("a5_bits_l", cap_l, 8'hA5);
        chk("a5_nbits", vcnt, 8);
        chk("a5_nfs", fscnt, 1);
        #2;
        chk("a5_end_valid", ser_valid_m, 1'b0);
        chk("a5_end_data", ser_data_m, 1'b0);

        // back-to-back 0xFF, 0x00
        clear_stats();
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'h00);
        idle(17);
        chk("b2b_stream", cap16, 16'hFF00);
        chk("b2b_nbits", vcnt, 16);
        chk("b2b_nfs", fscnt, 2);
        chk("b2b_rdy_low", rdylo, 7);

        // LSB-first ordering of 0x01
        clear_stats();
        step(1'b0, 1'b1, 8'h01);
        #2;
        chk("lsb_first_bit", ser_data_l, 1'b1);
        chk("msb_first_bit", ser_data_m, 1'b0);
        idle(9);
        chk("lsb_word", cap_l, 8'h01);

        // reset mid-word with a held word
        step(1'b0, 1'b1, 8'hF0);
        step(1'b0, 1'b1, 8'h3C);
        idle(2);
        step(1'b1, 1'b0, '0);
        #2;
        chk("mid_rst_valid", ser_valid_m, 1'b0);
        chk("mid_rst_data_m", ser_data_m, 1'b0);
        chk("mid_rst_data_l", ser_data_l, 1'b1);
        chk("mid_rst_ready", in_ready_m, 1'b0);
        clear_stats();
        step(1'b0, 1'b0, '0);
        #2;
        chk("post_rst_ready", in_ready_m, 1'b1);
        idle(10);
        chk("post_rst_stale", vcnt, 0);

        // accept on the last-bit edge with hold empty
        step(1'b0, 1'b1, 8'h3C);
        idle(7);
        clear_stats();
        step(1'b0, 1'b1, 8'hC3);
        #2;
        chk("lastbit_fs", frame_start_m, 1'b1);
        chk("lastbit_valid", ser_valid_m, 1'b1);
        chk("lastbit_data", ser_data_m, 1'b1);
        idle(10);

        // 0x05 then 0x80 into a 1-0-1 detector
        clear_stats();
        step(1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, 8'h80);
        idle(18);
        chk("det_pulses", detcnt, 1);

        // randomized traffic with occasional resets
        cur_v = 1'b0; cur_d = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!(cur_v && !last_acc)) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = W'($urandom);
            end
            r_rand = ($urandom_range(0, 59) == 0);
            step(r_rand, cur_v, cur_d);
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
